ccd_line_sequencer: RTL and testbench



---
 rtl/ccd_pkg.sv | 34 +++
 rtl/ccd_line_sequencer_adc_serial_rx.sv | 89 ++++++++
 rtl/ccd_line_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_ccd_line_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccd_pkg.sv
// Shared types and default timing constants for the linear-CCD line sequencer.
// Holds the line state enum, default phase positions and the pixel word type.
package ccd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLOCKING,
        ST_INT_WAIT,
        ST_SH_PRE,
        ST_SH_HIGH,
        ST_SH_POST
    } state_t;

    localparam int PIX_TOTAL_DEF  = 2100;
    localparam int ACT_FIRST_DEF  = 1;
    localparam int ACT_LAST_DEF   = 2087;
    localparam int CAL_FIRST_DEF  = 32;
    localparam int CAL_LAST_DEF   = 2079;
    localparam int PIX_PERIOD_DEF = 40;
    localparam int P1_HI_DEF      = 4;
    localparam int P1_LO_DEF      = 24;
    localparam int RS_HI_DEF      = 1;
    localparam int RS_LO_DEF      = 5;
    localparam int CP_HI_DEF      = 8;
    localparam int CP_LO_DEF      = 14;
    localparam int CS_POS_DEF     = 29;
    localparam int ADC_BITS_DEF   = 16;
    localparam int SH_PRE_DEF     = 40;
    localparam int SH_WIDTH_DEF   = 4;
    localparam int SH_POST_DEF    = 40;

    typedef logic [ADC_BITS_DEF-1:0] pix_word_t;

endpackage

// File: rtl/ccd_line_sequencer_adc_serial_rx.sv
// Serial ADC frame engine: on launch drives cs/sclk, shifts adc_sdo in MSB
// first and emits one word with the tags captured at launch.
// Ports: clk_80M, rst, launch, abort, tag_valid/sol/eol in; adc_cs, adc_sclk
// out; adc_sdo in; word_valid, word, word_sol, word_eol out.
module adc_serial_rx
    import ccd_pkg::*;
#(
    parameter int ADC_BITS = ADC_BITS_DEF
) (
    input  logic                clk_80M,
    input  logic                rst,
    input  logic                launch,
    input  logic                abort,
    input  logic                tag_valid,
    input  logic                tag_sol,
    input  logic                tag_eol,
    output logic                adc_cs,
    output logic                adc_sclk,
    input  logic                adc_sdo,
    output logic                word_valid,
    output logic [ADC_BITS-1:0] word,
    output logic                word_sol,
    output logic                word_eol
);

    localparam int KW = $clog2(2 * ADC_BITS + 2);
    localparam logic [KW-1:0] K_END = KW'(2 * ADC_BITS + 1);

    logic                active;
    logic [KW-1:0]       k;
    logic [KW-1:0]       kn;
    logic [ADC_BITS-1:0] shreg;
    logic                t_v;
    logic                t_s;
    logic                t_e;

    // k is the frame cycle currently on the pins; kn is the one being set up
    assign kn = k + 1'b1;

    always_ff @(posedge clk_80M) begin
        if (rst || abort) begin
            active     <= 1'b0;
            k          <= '0;
            adc_cs     <= 1'b1;
            adc_sclk   <= 1'b0;
            shreg      <= '0;
            t_v        <= 1'b0;
            t_s        <= 1'b0;
            t_e        <= 1'b0;
            word_valid <= 1'b0;
            word_sol   <= 1'b0;
            word_eol   <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            word_sol   <= 1'b0;
            word_eol   <= 1'b0;
            if (active) begin
                k <= kn;
                if (kn == K_END) begin
                    active     <= 1'b0;
                    adc_cs     <= 1'b1;
                    adc_sclk   <= 1'b0;
                    word_valid <= t_v;
                    word_sol   <= t_v & t_s;
                    word_eol   <= t_v & t_e;
                    if (t_v) begin
                        word <= shreg;
                    end
                end else if (kn[0]) begin
                    adc_sclk <= 1'b1;
                end else begin
                    // falling sclk: take the bit presented during the high phase
                    adc_sclk <= 1'b0;
                    shreg    <= {shreg[ADC_BITS-2:0], adc_sdo};
                end
            end else if (launch) begin
                active   <= 1'b1;
                k        <= '0;
                adc_cs   <= 1'b0;
                adc_sclk <= 1'b0;
                t_v      <= tag_valid;
                t_s      <= tag_sol;
                t_e      <= tag_eol;
            end
        end
    end

endmodule

// File: rtl/ccd_line_sequencer.sv
// Linear-CCD line sequencer: pixel clocks, RS/CP/SH pulses, ADC framing and
// a single-clock pixel stream with sol/eol flags.
// Ports: clk_80M, rst, en, continuous, start, cal_mode, int_extra in;
// ccd_p1/p2/rs/cp/sh, adc_cs, adc_sclk out; adc_sdo in; pix_valid,
// pix_data, pix_sol, pix_eol, line_cnt, busy out.
module ccd_line_sequencer
    import ccd_pkg::*;
#(
    parameter int PIX_TOTAL  = PIX_TOTAL_DEF,
    parameter int ACT_FIRST  = ACT_FIRST_DEF,
    parameter int ACT_LAST   = ACT_LAST_DEF,
    parameter int CAL_FIRST  = CAL_FIRST_DEF,
    parameter int CAL_LAST   = CAL_LAST_DEF,
    parameter int PIX_PERIOD = PIX_PERIOD_DEF,
    parameter int P1_HI      = P1_HI_DEF,
    parameter int P1_LO      = P1_LO_DEF,
    parameter int RS_HI      = RS_HI_DEF,
    parameter int RS_LO      = RS_LO_DEF,
    parameter int CP_HI      = CP_HI_DEF,
    parameter int CP_LO      = CP_LO_DEF,
    parameter int CS_POS     = CS_POS_DEF,
    parameter int ADC_BITS   = ADC_BITS_DEF,
    parameter int SH_PRE     = SH_PRE_DEF,
    parameter int SH_WIDTH   = SH_WIDTH_DEF,
    parameter int SH_POST    = SH_POST_DEF
) (
    input  logic                clk_80M,
    input  logic                rst,
    input  logic                en,
    input  logic                continuous,
    input  logic                start,
    input  logic                cal_mode,
    input  logic [15:0]         int_extra,
    output logic                ccd_p1,
    output logic                ccd_p2,
    output logic                ccd_rs,
    output logic                ccd_cp,
    output logic                ccd_sh,
    output logic                adc_cs,
    output logic                adc_sclk,
    input  logic                adc_sdo,
    output logic                pix_valid,
    output logic [ADC_BITS-1:0] pix_data,
    output logic                pix_sol,
    output logic                pix_eol,
    output logic [15:0]         line_cnt,
    output logic                busy
);

    localparam int PW = $clog2(PIX_PERIOD);
    localparam int XW = $clog2(PIX_TOTAL);

    localparam logic [PW-1:0] PH_LAST = PW'(PIX_PERIOD - 1);
    localparam logic [PW-1:0] PH_P1HI = PW'(P1_HI);
    localparam logic [PW-1:0] PH_P1LO = PW'(P1_LO);
    localparam logic [PW-1:0] PH_RSHI = PW'(RS_HI);
    localparam logic [PW-1:0] PH_RSLO = PW'(RS_LO);
    localparam logic [PW-1:0] PH_CPHI = PW'(CP_HI);
    localparam logic [PW-1:0] PH_CPLO = PW'(CP_LO);
    localparam logic [PW-1:0] PH_CS   = PW'(CS_POS);

    localparam logic [XW-1:0] PX_LAST = XW'(PIX_TOTAL - 1);
    localparam logic [XW-1:0] ACT_LO  = XW'(ACT_FIRST);
    localparam logic [XW-1:0] ACT_HI  = XW'(ACT_LAST);
    localparam logic [XW-1:0] CAL_LO  = XW'(CAL_FIRST);
    localparam logic [XW-1:0] CAL_HI  = XW'(CAL_LAST);

    localparam logic [15:0] T_PRE  = 16'(SH_PRE - 1);
    localparam logic [15:0] T_HIGH = 16'(SH_WIDTH - 1);
    localparam logic [15:0] T_POST = 16'(SH_POST - 1);

    state_t        state;
    state_t        state_d;
    logic [15:0]   tmr;
    logic [15:0]   tmr_d;
    logic [PW-1:0] phase;
    logic [XW-1:0] pix;
    logic          last_cyc;
    logic          line_done;
    logic          run;
    logic [XW-1:0] rng_lo;
    logic [XW-1:0] rng_hi;
    logic          launch;

    assign last_cyc = (phase == PH_LAST) && (pix == PX_LAST);
    assign busy     = (state != ST_IDLE);
    assign ccd_p2   = ~ccd_p1;

    // Staying in CLOCKING is the only case where the CCD edge table applies
    assign run = (state == ST_CLOCKING) && (state_d == ST_CLOCKING);

    always_ff @(posedge clk_80M) begin
        if (rst) begin
            state <= ST_IDLE;
            tmr   <= '0;
        end else begin
            state <= state_d;
            tmr   <= tmr_d;
        end
    end

    always_comb begin
        state_d   = state;
        line_done = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (en && (continuous || start)) state_d = ST_CLOCKING;
            end
            ST_CLOCKING: begin
                if (last_cyc) begin
                    state_d = (int_extra != 16'd0) ? ST_INT_WAIT : ST_SH_PRE;
                end
            end
            ST_INT_WAIT: begin
                if (tmr == 16'd0) state_d = ST_SH_PRE;
            end
            ST_SH_PRE: begin
                if (tmr == 16'd0) state_d = ST_SH_HIGH;
            end
            ST_SH_HIGH: begin
                if (tmr == 16'd0) state_d = ST_SH_POST;
            end
            ST_SH_POST: begin
                if (tmr == 16'd0) begin
                    line_done = 1'b1;
                    state_d   = (en && continuous) ? ST_CLOCKING : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!en) begin
            state_d   = ST_IDLE;
            line_done = 1'b0;
        end
    end

    // Timed states load duration-1 on entry and leave when the count hits 0
    always_comb begin
        tmr_d = (tmr != 16'd0) ? tmr - 16'd1 : 16'd0;
        if (state_d != state) begin
            case (state_d)
                ST_INT_WAIT: tmr_d = int_extra - 16'd1;
                ST_SH_PRE:   tmr_d = T_PRE;
                ST_SH_HIGH:  tmr_d = T_HIGH;
                ST_SH_POST:  tmr_d = T_POST;
                default:     tmr_d = 16'd0;
            endcase
        end
    end

    always_ff @(posedge clk_80M) begin
        if (rst) begin
            phase    <= '0;
            pix      <= '0;
            ccd_p1   <= 1'b1;
            ccd_rs   <= 1'b0;
            ccd_cp   <= 1'b0;
            ccd_sh   <= 1'b0;
            line_cnt <= '0;
        end else begin
            if (line_done) line_cnt <= line_cnt + 16'd1;
            ccd_sh <= (state_d == ST_SH_HIGH);
            if (run) begin
                if (phase == PH_LAST) begin
                    phase <= '0;
                    pix   <= pix + 1'b1;
                end else begin
                    phase <= phase + 1'b1;
                end
                if (phase == PH_P1HI) ccd_p1 <= 1'b1;
                else if (phase == PH_P1LO) ccd_p1 <= 1'b0;
                if (phase == PH_RSHI) ccd_rs <= 1'b1;
                else if (phase == PH_RSLO) ccd_rs <= 1'b0;
                if (phase == PH_CPHI) ccd_cp <= 1'b1;
                else if (phase == PH_CPLO) ccd_cp <= 1'b0;
            end else begin
                phase  <= '0;
                pix    <= '0;
                ccd_p1 <= 1'b1;
                ccd_rs <= 1'b0;
                ccd_cp <= 1'b0;
            end
        end
    end

    // Range is picked per frame, so a cal_mode change hits the next launch
    assign rng_lo = cal_mode ? CAL_LO : ACT_LO;
    assign rng_hi = cal_mode ? CAL_HI : ACT_HI;
    assign launch = (state == ST_CLOCKING) && (phase == PH_CS);

    adc_serial_rx #(
        .ADC_BITS(ADC_BITS)
    ) u_adc (
        .clk_80M   (clk_80M),
        .rst       (rst),
        .launch    (launch),
        .abort     (!en),
        .tag_valid ((pix >= rng_lo) && (pix <= rng_hi)),
        .tag_sol   (pix == rng_lo),
        .tag_eol   (pix == rng_hi),
        .adc_cs    (adc_cs),
        .adc_sclk  (adc_sclk),
        .adc_sdo   (adc_sdo),
        .word_valid(pix_valid),
        .word      (pix_data),
        .word_sol  (pix_sol),
        .word_eol  (pix_eol)
    );

endmodule

// File: tb/tb_ccd_line_sequencer.sv
// Directed bench for ccd_line_sequencer on a short 8-pixel line.
// ADC model returns 0xA5A5 + pixel index for every frame.
module tb_ccd_line_sequencer;

    logic        clk_80M = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        continuous = 1'b0;
    logic        start = 1'b0;
    logic        cal_mode = 1'b0;
    logic [15:0] int_extra = 16'd0;
    logic        ccd_p1, ccd_p2, ccd_rs, ccd_cp, ccd_sh;
    logic        adc_cs, adc_sclk;
    logic        adc_sdo = 1'b0;
    logic        pix_valid, pix_sol, pix_eol, busy;
    logic [15:0] pix_data;
    logic [15:0] line_cnt;

    ccd_line_sequencer #(
        .PIX_TOTAL(8),
        .ACT_FIRST(1),
        .ACT_LAST (5),
        .CAL_FIRST(2),
        .CAL_LAST (3)
    ) dut (
        .clk_80M   (clk_80M),
        .rst       (rst),
        .en        (en),
        .continuous(continuous),
        .start     (start),
        .cal_mode  (cal_mode),
        .int_extra (int_extra),
        .ccd_p1    (ccd_p1),
        .ccd_p2    (ccd_p2),
        .ccd_rs    (ccd_rs),
        .ccd_cp    (ccd_cp),
        .ccd_sh    (ccd_sh),
        .adc_cs    (adc_cs),
        .adc_sclk  (adc_sclk),
        .adc_sdo   (adc_sdo),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_sol   (pix_sol),
        .pix_eol   (pix_eol),
        .line_cnt  (line_cnt),
        .busy      (busy)
    );

    always #5 clk_80M = ~clk_80M;

    typedef struct packed {
        logic [15:0] d;
        logic        s;
        logic        e;
    } wrd_t;

    typedef struct {
        logic        cal;
        logic [15:0] ext;
        int          n;
        int          first;
        int          len;
    } vec_t;

    localparam logic [10:0] RST_GRP = 11'b10000100000;

    wrd_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   busy_cyc = 0;
    int   sh_cyc = 0;
    int   p1_low = 0;
    int   p2_bad = 0;
    int   fidx = 0;
    logic [15:0] adc_word = 16'd0;
    logic cs_d = 1'b1;
    logic sclk_d = 1'b0;
    logic busy_d = 1'b0;
    vec_t vt[4];
    int   meas[4];

    // ADC model and monitors, all sampled mid-cycle
    always @(negedge clk_80M) begin
        if (busy && !busy_d) fidx = 0;
        if (!adc_cs && cs_d) begin
            adc_word = 16'hA5A5 + 16'(fidx);
            fidx = (fidx + 1) % 8;
        end else if (!adc_sclk && sclk_d) begin
            adc_word = {adc_word[14:0], 1'b0};
        end
        adc_sdo = adc_word[15];
        if (busy) begin
            busy_cyc++;
            if (!ccd_p1) p1_low++;
        end
        if (ccd_sh) sh_cyc++;
        if (ccd_p2 !== ~ccd_p1) p2_bad++;
        if (pix_valid) q.push_back({pix_data, pix_sol, pix_eol});
        cs_d = adc_cs;
        sclk_d = adc_sclk;
        busy_d = busy;
    end

    task automatic tick();
        @(posedge clk_80M);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [10:0] grp();
        return {ccd_p1, ccd_p2, ccd_rs, ccd_cp, ccd_sh, adc_cs, adc_sclk,
                pix_valid, pix_sol, pix_eol, busy};
    endfunction

    task automatic run_line(input vec_t v, input int id);
        int b0, s0, p0, pb0, q0, k;
        logic [15:0] lc0;
        cal_mode = v.cal;
        int_extra = v.ext;
        b0 = busy_cyc;
        s0 = sh_cyc;
        p0 = p1_low;
        pb0 = p2_bad;
        q0 = q.size();
        lc0 = line_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_latency_busy", 32'(busy), 1);
        k = 0;
        while (busy && k < 3000) begin
            tick();
            k++;
        end
        chk("line_end", 32'(busy), 0);
        chk("word_count", q.size() - q0, v.n);
        for (int i = 0; i < v.n && q0 + i < q.size(); i++) begin
            chk("word_data", 32'(q[q0+i].d), 32'(16'hA5A5 + 16'(v.first + i)));
            chk("word_sol", 32'(q[q0+i].s), 32'(i == 0));
            chk("word_eol", 32'(q[q0+i].e), 32'(i == v.n - 1));
        end
        meas[id] = busy_cyc - b0;
        chk("line_len", meas[id], v.len);
        chk("sh_width", sh_cyc - s0, 4);
        chk("p1_low_cycles", p1_low - p0, 155);
        chk("p2_inverse", p2_bad - pb0, 0);
        chk("line_cnt_inc", 32'(line_cnt), 32'(lc0 + 16'd1));
        chk("data_hold", 32'(pix_data), 32'(16'hA5A5 + 16'(v.first + v.n - 1)));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, q0, b0, bad;
        logic [15:0] base;

        vt[0] = '{1'b0, 16'd0,   5, 1, 404};
        vt[1] = '{1'b1, 16'd0,   2, 2, 404};
        vt[2] = '{1'b0, 16'd100, 5, 1, 504};
        vt[3] = '{1'b1, 16'd7,   2, 2, 411};

        repeat (3) tick();
        chk("reset_outputs", 32'(grp()), 32'(RST_GRP));
        chk("reset_data", 32'(pix_data), 0);
        chk("reset_line_cnt", 32'(line_cnt), 0);
        rst = 1'b0;
        tick();
        chk("idle_no_start", 32'(busy), 0);
        en = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            run_line(vt[i], i);
            repeat (5) tick();
        end
        chk("int_extra_delta", meas[2] - meas[0], 100);

        // en dropped while bit 7 is on the wire
        cal_mode = 1'b0;
        int_extra = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (adc_cs && k < 200) begin
            tick();
            k++;
        end
        chk("cs_low_seen", 32'(adc_cs), 0);
        repeat (17) tick();
        chk("bit7_sclk_high", 32'(adc_sclk), 1);
        q0 = q.size();
        en = 1'b0;
        tick();
        chk("abort_outputs", 32'(grp()), 32'(RST_GRP));
        chk("abort_data", 32'(pix_data), 0);
        chk("abort_keeps_cnt", 32'(line_cnt), 4);
        repeat (60) tick();
        chk("abort_no_valid", q.size() - q0, 0);
        en = 1'b1;
        tick();

        // clean restart with first-word latency
        q0 = q.size();
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (!pix_valid && k < 200) begin
            tick();
            k++;
        end
        chk("valid_latency", k, 103);
        chk("first_word", 32'(pix_data), 32'h0000A5A6);
        chk("first_sol", 32'(pix_sol), 1);
        k = 0;
        while (busy && k < 3000) begin
            tick();
            k++;
        end
        chk("restart_words", q.size() - q0, 5);
        chk("restart_line_cnt", 32'(line_cnt), 5);
        repeat (5) tick();

        // continuous lines; starts inside lines must do nothing
        base = line_cnt;
        q0 = q.size();
        b0 = busy_cyc;
        continuous = 1'b1;
        tick();
        chk("cont_busy", 32'(busy), 1);
        k = 0;
        while (line_cnt != base + 16'd2 && k < 3000) begin
            start = (k % 97 == 10);
            tick();
            k++;
        end
        start = 1'b0;
        continuous = 1'b0;
        k = 0;
        while (busy && k < 3000) begin
            start = (k % 97 == 10);
            tick();
            k++;
        end
        start = 1'b0;
        repeat (500) tick();
        chk("cont_line_cnt", 32'(line_cnt), 32'(base + 16'd3));
        chk("cont_idle", 32'(busy), 0);
        chk("cont_busy_cycles", busy_cyc - b0, 1212);
        chk("cont_words", q.size() - q0, 15);
        bad = 0;
        for (int i = 0; i < 15 && q0 + i < q.size(); i++) begin
            if (q[q0+i].d !== 16'hA5A5 + 16'(1 + i % 5)) bad++;
        end
        chk("cont_word_data", bad, 0);

        // synchronous reset in the middle of a frame
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (adc_cs && k < 200) begin
            tick();
            k++;
        end
        repeat (5) tick();
        q0 = q.size();
        rst = 1'b1;
        tick();
        chk("rst_mid_outputs", 32'(grp()), 32'(RST_GRP));
        chk("rst_mid_data", 32'(pix_data), 0);
        chk("rst_mid_line_cnt", 32'(line_cnt), 0);
        rst = 1'b0;
        repeat (60) tick();
        chk("rst_no_valid", q.size() - q0, 0);
        chk("rst_stays_idle", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
